// File: rtl/ahb_apb_bridge_if.sv
// Signal bundle between an AHB-Lite master / APB completer pair and the bridge.
// The bridge is the slave modport; the surrounding environment uses the master modport.
interface ahb_apb_bridge_if #(
   parameter int AHB_DW = 32,
   parameter int AHB_AW = 32
);
   logic [AHB_AW-1:0]   haddr;
   logic [1:0]          htrans;
   logic                hwrite;
   logic [2:0]          hsize;
   logic [2:0]          hburst;
   logic [AHB_DW-1:0]   hwdata;
   logic [AHB_DW-1:0]   hrdata;
   logic                hready;
   logic [AHB_AW-1:0]   paddr;
   logic                psel;
   logic                penable;
   logic                pwrite;
   logic [AHB_DW-1:0]   pwdata;
   logic [AHB_DW/8-1:0] pstrb;
   logic [AHB_DW-1:0]   prdata;
   logic                pready;

   modport slave (
      input  haddr, htrans, hwrite, hsize, hburst, hwdata, prdata, pready,
      output hrdata, hready, paddr, psel, penable, pwrite, pwdata, pstrb
   );

   modport master (
      output haddr, htrans, hwrite, hsize, hburst, hwdata, prdata, pready,
      input  hrdata, hready, paddr, psel, penable, pwrite, pwdata, pstrb
   );
endinterface

// File: rtl/ahb_apb_bridge.sv
// AHB-Lite slave to APB master bridge: one transfer at a time, IDLE -> DATA -> SETUP -> ACCESS,
// AHB stalled with hready low until the APB completer answers.
module ahb_apb_bridge #(
   parameter int AHB_DW = 32,
   parameter int AHB_AW = 32
) (
   input  logic             clk,
   input  logic             reset,
   ahb_apb_bridge_if.slave  bus
);
   localparam int NB = AHB_DW / 8;
   localparam int LW = $clog2(NB);

   typedef enum logic [1:0] {
      ST_IDLE   = 2'b00,
      ST_DATA   = 2'b01,
      ST_SETUP  = 2'b10,
      ST_ACCESS = 2'b11
   } state_t;

   state_t            state_r,   state_s;
   logic              hready_r,  hready_s;
   logic [AHB_DW-1:0] hrdata_r,  hrdata_s;
   logic              psel_r,    psel_s;
   logic              penable_r, penable_s;
   logic              pwrite_r,  pwrite_s;
   logic [AHB_AW-1:0] paddr_r,   paddr_s;
   logic [AHB_DW-1:0] pwdata_r,  pwdata_s;
   logic [NB-1:0]     pstrb_r,   pstrb_s;
   logic [NB-1:0]     mask_r,    mask_s;
   logic              burst_unused_s;

   // Byte lanes touched by a transfer; sizes wider than the bus collapse to a full-width access.
   function automatic logic [NB-1:0] lane_mask(input logic [AHB_AW-1:0] addr, input logic [2:0] size);
      int sz;
      int nbytes;
      int off;
      logic [NB-1:0] m;
      sz     = (int'(size) > LW) ? LW : int'(size);
      nbytes = 32'sd1 << sz;
      off    = int'(addr[LW-1:0]) & ~(nbytes - 32'sd1);
      m      = '0;
      for (int i = 0; i < NB; i++) begin
         m[i] = (i >= off) && (i < off + nbytes);
      end
      return m;
   endfunction

   // Every beat is an independent transfer, so the burst type carries no information here.
   assign burst_unused_s = ^bus.hburst;

   // Next-state and next-output logic.
   always_comb begin
      state_s   = state_r;
      hready_s  = hready_r;
      hrdata_s  = hrdata_r;
      psel_s    = psel_r;
      penable_s = penable_r;
      pwrite_s  = pwrite_r;
      paddr_s   = paddr_r;
      pwdata_s  = pwdata_r;
      pstrb_s   = pstrb_r;
      mask_s    = mask_r;
      case (state_r)
         ST_IDLE: begin
            if (bus.htrans[1]) begin
               paddr_s  = bus.haddr;
               pwrite_s = bus.hwrite;
               mask_s   = lane_mask(bus.haddr, bus.hsize);
               hready_s = 1'b0;
               state_s  = ST_DATA;
            end else begin
               state_s  = ST_IDLE;
            end
         end
         ST_DATA: begin
            // hwdata is only valid in the AHB data phase, one cycle after the address.
            if (pwrite_r) begin
               pwdata_s = bus.hwdata;
               pstrb_s  = mask_r;
            end else begin
               pstrb_s  = '0;
            end
            psel_s    = 1'b1;
            penable_s = 1'b0;
            state_s   = ST_SETUP;
         end
         ST_SETUP: begin
            penable_s = 1'b1;
            state_s   = ST_ACCESS;
         end
         ST_ACCESS: begin
            if (bus.pready) begin
               psel_s    = 1'b0;
               penable_s = 1'b0;
               hready_s  = 1'b1;
               if (!pwrite_r) begin
                  hrdata_s = bus.prdata;
               end else begin
                  hrdata_s = hrdata_r;
               end
               state_s   = ST_IDLE;
            end else begin
               state_s   = ST_ACCESS;
            end
         end
         default: begin
            psel_s    = 1'b0;
            penable_s = 1'b0;
            hready_s  = 1'b1;
            state_s   = ST_IDLE;
         end
      endcase
   end

   // State and registered outputs; reset abandons any transfer in flight.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_r   <= ST_IDLE;
         hready_r  <= 1'b1;
         hrdata_r  <= '0;
         psel_r    <= 1'b0;
         penable_r <= 1'b0;
         pwrite_r  <= 1'b0;
         paddr_r   <= '0;
         pwdata_r  <= '0;
         pstrb_r   <= '0;
         mask_r    <= '0;
      end else begin
         state_r   <= state_s;
         hready_r  <= hready_s;
         hrdata_r  <= hrdata_s;
         psel_r    <= psel_s;
         penable_r <= penable_s;
         pwrite_r  <= pwrite_s;
         paddr_r   <= paddr_s;
         pwdata_r  <= pwdata_s;
         pstrb_r   <= pstrb_s;
         mask_r    <= mask_s;
      end
   end

   assign bus.hready  = hready_r;
   assign bus.hrdata  = hrdata_r;
   assign bus.psel    = psel_r;
   assign bus.penable = penable_r;
   assign bus.pwrite  = pwrite_r;
   assign bus.paddr   = paddr_r;
   assign bus.pwdata  = pwdata_r;
   assign bus.pstrb   = pstrb_r;
endmodule

// File: tb/tb_ahb_apb_bridge.sv
// Directed self-checking bench for ahb_apb_bridge: reset, single write/read, lane strobes,
// idle/busy cycles, back-to-back burst and reset during ACCESS.
module tb_ahb_apb_bridge;
   logic clk;
   logic reset;
   int   checks;
   int   errors;
   int   cyc;

   int          low_cnt, setup_cnt, access_cnt, stable_err;
   logic [31:0] cap_paddr, cap_pwdata, cap_rdata;
   logic [3:0]  cap_pstrb;
   logic        cap_pwrite;
   int          psel_seen, hready_low;

   ahb_apb_bridge_if #(.AHB_DW(32), .AHB_AW(32)) bus ();

   ahb_apb_bridge #(.AHB_DW(32), .AHB_AW(32)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // One AHB transfer; returns at the negedge after completion with observations captured.
   task automatic run_xfer(input logic [31:0] addr, input logic wr, input logic [2:0] size,
                           input logic [31:0] wdata, input logic [31:0] rdata, input int waits,
                           input logic [1:0] trans, input logic early);
      bit done;
      bus.haddr  = addr;
      bus.htrans = trans;
      bus.hwrite = wr;
      bus.hsize  = size;
      bus.hburst = 3'b001;
      bus.prdata = rdata;
      bus.pready = early;
      low_cnt = 0; setup_cnt = 0; access_cnt = 0; stable_err = 0; done = 1'b0;
      cap_paddr = 32'h0; cap_pwdata = 32'h0; cap_pstrb = 4'h0; cap_pwrite = 1'b0;
      @(posedge clk); #1;
      bus.htrans = 2'b00;
      bus.hwdata = wdata;
      bus.haddr  = 32'hFFFF_FFFC;
      bus.hwrite = ~wr;
      for (int c = 0; c < 64; c++) begin
         @(negedge clk);
         if (bus.hready) begin
            done = 1'b1;
            break;
         end
         low_cnt++;
         if (bus.psel && !bus.penable) begin
            setup_cnt++;
            cap_paddr  = bus.paddr;
            cap_pwdata = bus.pwdata;
            cap_pstrb  = bus.pstrb;
            cap_pwrite = bus.pwrite;
            bus.pready = early;
         end else if (bus.psel && bus.penable) begin
            access_cnt++;
            if (bus.paddr !== cap_paddr || bus.pwdata !== cap_pwdata ||
                bus.pstrb !== cap_pstrb || bus.pwrite !== cap_pwrite) stable_err++;
            bus.pready = (access_cnt > waits);
         end else begin
            bus.pready = early;
         end
      end
      if (!done) low_cnt = -1;
      cap_rdata  = bus.hrdata;
      bus.pready = 1'b0;
   endtask

   task automatic idle_cycles(input int n, input logic [1:0] trans, input logic pr);
      psel_seen = 0; hready_low = 0;
      bus.htrans = trans;
      bus.pready = pr;
      repeat (n) begin
         @(negedge clk);
         if (bus.psel) psel_seen++;
         if (!bus.hready) hready_low++;
      end
      bus.htrans = 2'b00;
      bus.pready = 1'b0;
   endtask

   task automatic test_reset;
      #2;
      checks += 8;
      if (bus.hready !== 1'b1) begin errors++; $display("FAIL reset_hready got %b want 1", bus.hready); end
      if (bus.psel !== 1'b0) begin errors++; $display("FAIL reset_psel got %b want 0", bus.psel); end
      if (bus.penable !== 1'b0) begin errors++; $display("FAIL reset_penable got %b want 0", bus.penable); end
      if (bus.pwrite !== 1'b0) begin errors++; $display("FAIL reset_pwrite got %b want 0", bus.pwrite); end
      if (bus.hrdata !== 32'h0) begin errors++; $display("FAIL reset_hrdata got %h want 0", bus.hrdata); end
      if (bus.paddr !== 32'h0) begin errors++; $display("FAIL reset_paddr got %h want 0", bus.paddr); end
      if (bus.pwdata !== 32'h0) begin errors++; $display("FAIL reset_pwdata got %h want 0", bus.pwdata); end
      if (bus.pstrb !== 4'h0) begin errors++; $display("FAIL reset_pstrb got %h want 0", bus.pstrb); end
      @(negedge clk);
      reset = 1'b0;
   endtask

   task automatic test_write;
      run_xfer(32'h10, 1'b1, 3'd2, 32'hDEADBEEF, 32'h0, 0, 2'b10, 1'b0);
      checks += 9;
      if (low_cnt !== 3) begin errors++; $display("FAIL wr_hready_low got %0d want 3", low_cnt); end
      if (setup_cnt !== 1) begin errors++; $display("FAIL wr_setup got %0d want 1", setup_cnt); end
      if (access_cnt !== 1) begin errors++; $display("FAIL wr_access got %0d want 1", access_cnt); end
      if (cap_paddr !== 32'h10) begin errors++; $display("FAIL wr_paddr got %h want 10", cap_paddr); end
      if (cap_pwdata !== 32'hDEADBEEF) begin errors++; $display("FAIL wr_pwdata got %h want deadbeef", cap_pwdata); end
      if (cap_pstrb !== 4'hF) begin errors++; $display("FAIL wr_pstrb got %h want f", cap_pstrb); end
      if (cap_pwrite !== 1'b1) begin errors++; $display("FAIL wr_pwrite got %b want 1", cap_pwrite); end
      if (stable_err !== 0) begin errors++; $display("FAIL wr_stable got %0d want 0", stable_err); end
      if (cap_rdata !== 32'h0) begin errors++; $display("FAIL wr_hrdata got %h want 0", cap_rdata); end
   endtask

   task automatic test_read_wait;
      run_xfer(32'h24, 1'b0, 3'd2, 32'hA5A5A5A5, 32'h12345678, 2, 2'b10, 1'b1);
      checks += 8;
      if (low_cnt !== 5) begin errors++; $display("FAIL rd_hready_low got %0d want 5", low_cnt); end
      if (setup_cnt !== 1) begin errors++; $display("FAIL rd_setup got %0d want 1", setup_cnt); end
      if (access_cnt !== 3) begin errors++; $display("FAIL rd_access got %0d want 3", access_cnt); end
      if (cap_paddr !== 32'h24) begin errors++; $display("FAIL rd_paddr got %h want 24", cap_paddr); end
      if (cap_pstrb !== 4'h0) begin errors++; $display("FAIL rd_pstrb got %h want 0", cap_pstrb); end
      if (cap_pwrite !== 1'b0) begin errors++; $display("FAIL rd_pwrite got %b want 0", cap_pwrite); end
      if (stable_err !== 0) begin errors++; $display("FAIL rd_stable got %0d want 0", stable_err); end
      if (cap_rdata !== 32'h12345678) begin errors++; $display("FAIL rd_hrdata got %h want 12345678", cap_rdata); end
   endtask

   task automatic test_lanes;
      logic [31:0] addrs [5] = '{32'h03, 32'h02, 32'h01, 32'h05, 32'h03};
      logic [2:0]  sizes [5] = '{3'd0, 3'd1, 3'd0, 3'd3, 3'd1};
      logic [3:0]  strbs [5] = '{4'h8, 4'hC, 4'h2, 4'hF, 4'hC};
      for (int i = 0; i < 5; i++) begin
         run_xfer(addrs[i], 1'b1, sizes[i], 32'h0BAD_F00D + i, 32'h0, 0, 2'b10, 1'b0);
         checks += 3;
         if (cap_pstrb !== strbs[i]) begin errors++; $display("FAIL lane%0d_pstrb got %h want %h", i, cap_pstrb, strbs[i]); end
         if (cap_paddr !== addrs[i]) begin errors++; $display("FAIL lane%0d_paddr got %h want %h", i, cap_paddr, addrs[i]); end
         if (cap_rdata !== 32'h12345678) begin errors++; $display("FAIL lane%0d_hrdata got %h want 12345678", i, cap_rdata); end
      end
   endtask

   task automatic test_idle;
      idle_cycles(10, 2'b00, 1'b1);
      checks += 3;
      if (psel_seen !== 0) begin errors++; $display("FAIL idle_psel got %0d want 0", psel_seen); end
      if (hready_low !== 0) begin errors++; $display("FAIL idle_hready got %0d want 0", hready_low); end
      if (bus.hrdata !== 32'h12345678) begin errors++; $display("FAIL idle_hrdata got %h want 12345678", bus.hrdata); end
   endtask

   task automatic test_back_to_back;
      int c0;
      c0 = cyc;
      run_xfer(32'h100, 1'b1, 3'd2, 32'h1111_0000, 32'h0, 0, 2'b10, 1'b0);
      checks += 2;
      if (cap_paddr !== 32'h100) begin errors++; $display("FAIL b0_paddr got %h want 100", cap_paddr); end
      if (low_cnt !== 3) begin errors++; $display("FAIL b0_hready_low got %0d want 3", low_cnt); end
      run_xfer(32'h104, 1'b1, 3'd2, 32'h1111_0001, 32'h0, 0, 2'b11, 1'b0);
      checks += 3;
      if (cap_paddr !== 32'h104) begin errors++; $display("FAIL b1_paddr got %h want 104", cap_paddr); end
      if (cap_pwdata !== 32'h1111_0001) begin errors++; $display("FAIL b1_pwdata got %h want 11110001", cap_pwdata); end
      if (cyc - c0 !== 8) begin errors++; $display("FAIL b2b_cycles got %0d want 8", cyc - c0); end
      idle_cycles(2, 2'b01, 1'b0);
      checks += 2;
      if (psel_seen !== 0) begin errors++; $display("FAIL busy_psel got %0d want 0", psel_seen); end
      if (hready_low !== 0) begin errors++; $display("FAIL busy_hready got %0d want 0", hready_low); end
      for (int i = 2; i < 4; i++) begin
         run_xfer(32'h100 + 32'(4 * i), 1'b1, 3'd2, 32'h1111_0000 + 32'(i), 32'h0, 0, 2'b11, 1'b0);
         checks += 2;
         if (cap_paddr !== 32'h100 + 32'(4 * i)) begin errors++; $display("FAIL b%0d_paddr got %h want %h", i, cap_paddr, 32'h100 + 32'(4 * i)); end
         if (low_cnt !== 3) begin errors++; $display("FAIL b%0d_hready_low got %0d want 3", i, low_cnt); end
      end
   endtask

   task automatic test_reset_mid_access;
      bus.haddr  = 32'h40;
      bus.htrans = 2'b10;
      bus.hwrite = 1'b1;
      bus.hsize  = 3'd2;
      bus.pready = 1'b0;
      @(posedge clk); #1;
      bus.htrans = 2'b00;
      bus.hwdata = 32'h0000_0011;
      repeat (3) @(negedge clk);
      checks += 1;
      if (!(bus.psel === 1'b1 && bus.penable === 1'b1)) begin errors++; $display("FAIL rst_pre_access got psel=%b penable=%b want 1/1", bus.psel, bus.penable); end
      #2 reset = 1'b1;
      #1;
      checks += 5;
      if (bus.psel !== 1'b0) begin errors++; $display("FAIL rst_mid_psel got %b want 0", bus.psel); end
      if (bus.penable !== 1'b0) begin errors++; $display("FAIL rst_mid_penable got %b want 0", bus.penable); end
      if (bus.hready !== 1'b1) begin errors++; $display("FAIL rst_mid_hready got %b want 1", bus.hready); end
      if (bus.pstrb !== 4'h0) begin errors++; $display("FAIL rst_mid_pstrb got %h want 0", bus.pstrb); end
      if (bus.hrdata !== 32'h0) begin errors++; $display("FAIL rst_mid_hrdata got %h want 0", bus.hrdata); end
      @(negedge clk);
      reset = 1'b0;
      run_xfer(32'h48, 1'b0, 3'd2, 32'h0, 32'hCAFEF00D, 0, 2'b10, 1'b0);
      checks += 3;
      if (low_cnt !== 3) begin errors++; $display("FAIL post_rst_hready_low got %0d want 3", low_cnt); end
      if (cap_paddr !== 32'h48) begin errors++; $display("FAIL post_rst_paddr got %h want 48", cap_paddr); end
      if (cap_rdata !== 32'hCAFEF00D) begin errors++; $display("FAIL post_rst_hrdata got %h want cafef00d", cap_rdata); end
   endtask

   initial begin
      checks = 0;
      errors = 0;
      cyc    = 0;
      reset  = 1'b1;
      bus.haddr  = 32'h0;
      bus.htrans = 2'b00;
      bus.hwrite = 1'b0;
      bus.hsize  = 3'd0;
      bus.hburst = 3'd0;
      bus.hwdata = 32'h0;
      bus.prdata = 32'h0;
      bus.pready = 1'b0;
      test_reset();
      test_write();
      test_read_wait();
      test_lanes();
      test_idle();
      test_back_to_back();
      test_reset_mid_access();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
